// File: rtl/lr35902_oam_dma_if.sv
// OAM DMA bus bundle: FF46 register port, source read side, OAM write side.
// master = DMA controller, slave = video top level / source memories.
interface lr35902_oam_dma_if;
    logic [7:0]  reg_din;
    logic        reg_write;
    logic [7:0]  reg_dout;
    logic [15:0] adr_rd;
    logic        read;
    logic [7:0]  din;
    logic [7:0]  adr_wr;
    logic [7:0]  dout;
    logic        write;
    logic        active;
    logic        drvext;

    modport master (
        input  reg_din, reg_write, din,
        output reg_dout, adr_rd, read, adr_wr, dout, write, active, drvext
    );

    modport slave (
        output reg_din, reg_write, din,
        input  reg_dout, adr_rd, read, adr_wr, dout, write, active, drvext
    );
endinterface

// File: rtl/lr35902_oam_dma.sv
// LR35902 OAM DMA: FF46 register, copies page XX00-XX9F into OAM FE00-FE9F.
// Outputs are registered one clock behind the state they describe.
module lr35902_oam_dma #(
    parameter int START_DELAY = 4,
    parameter int NUM_BYTES   = 160,
    parameter int ECHO_FOLD   = 1
) (
    input logic               clk,
    input logic               reset,
    lr35902_oam_dma_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    localparam logic [7:0] LAST  = 8'(NUM_BYTES - 1);
    localparam logic [7:0] DELAY = 8'(START_DELAY - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [1:0]  phase, phase_n;
    logic [7:0]  index, index_n;
    logic [7:0]  page, page_n;
    logic [7:0]  reg_q, reg_n;

    logic [15:0] adr_rd_q, adr_rd_n;
    logic [7:0]  adr_wr_q, adr_wr_n;
    logic [7:0]  dout_q, dout_n;
    logic        read_q, read_n;
    logic        write_q, write_n;
    logic        active_q, active_n;
    logic        drvext_q, drvext_n;

    // Echo RAM pages E0-FF alias WRAM C0-DF
    function automatic logic [7:0] fold(input logic [7:0] p);
        logic [7:0] f;
        f = p;
        if (ECHO_FOLD != 0 && p[7:5] == 3'b111)
            f[5] = 1'b0;
        return f;
    endfunction

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            phase    <= 2'd0;
            index    <= 8'd0;
            page     <= 8'd0;
            reg_q    <= 8'hFF;
            adr_rd_q <= 16'd0;
            adr_wr_q <= 8'd0;
            dout_q   <= 8'hFF;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            active_q <= 1'b0;
            drvext_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            phase    <= phase_n;
            index    <= index_n;
            page     <= page_n;
            reg_q    <= reg_n;
            adr_rd_q <= adr_rd_n;
            adr_wr_q <= adr_wr_n;
            dout_q   <= dout_n;
            read_q   <= read_n;
            write_q  <= write_n;
            active_q <= active_n;
            drvext_q <= drvext_n;
        end
    end

    // Next-state: start delay, then 4-phase byte loop; a register write restarts
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        phase_n = phase;
        index_n = index;
        page_n  = page;
        reg_n   = reg_q;
        unique case (state)
            IDLE: ;
            START: begin
                if (cnt == 8'd0) begin
                    state_n = XFER;
                    phase_n = 2'd0;
                    index_n = 8'd0;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            XFER: begin
                if (phase == 2'd3) begin
                    if (index == LAST) begin
                        state_n = IDLE;
                    end else begin
                        index_n = index + 8'd1;
                        phase_n = 2'd0;
                    end
                end else begin
                    phase_n = phase + 2'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (bus.reg_write) begin
            page_n  = fold(bus.reg_din);
            reg_n   = bus.reg_din;
            state_n = START;
            cnt_n   = DELAY;
            index_n = 8'd0;
            phase_n = 2'd0;
        end
    end

    // Output decode from current state; addresses hold when idle
    always_comb begin
        adr_rd_n = adr_rd_q;
        adr_wr_n = adr_wr_q;
        dout_n   = dout_q;
        read_n   = 1'b0;
        write_n  = 1'b0;
        active_n = 1'b0;
        drvext_n = 1'b0;
        if (state == XFER) begin
            active_n = 1'b1;
            drvext_n = (page[7:5] != 3'b100);
            if (phase == 2'd3) begin
                write_n  = 1'b1;
                adr_wr_n = index;
                dout_n   = bus.din;
            end else begin
                read_n   = 1'b1;
                adr_rd_n = {page, index};
            end
        end
    end

    assign bus.reg_dout = reg_q;
    assign bus.adr_rd   = adr_rd_q;
    assign bus.adr_wr   = adr_wr_q;
    assign bus.dout     = dout_q;
    assign bus.read     = read_q;
    assign bus.write    = write_q;
    assign bus.active   = active_q;
    assign bus.drvext   = drvext_q;

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// Directed bench for lr35902_oam_dma.
// Source memory returns low address byte ^ 0x5A.
module tb_lr35902_oam_dma;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    lr35902_oam_dma_if bus ();

    lr35902_oam_dma dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.din = bus.adr_rd[7:0] ^ 8'h5A;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks n transfer cycles, counting any cycle that deviates
    task automatic scan(input logic [7:0] src, input logic drv, input int n,
                        output int bad, output int nwr,
                        output logic [7:0] d10);
        logic [7:0] idx;
        int ph;
        bad = 0;
        nwr = 0;
        d10 = 8'h00;
        for (int j = 0; j < n; j++) begin
            idx = 8'(j / 4);
            ph  = j % 4;
            step();
            if (bus.active !== 1'b1 || bus.drvext !== drv) bad++;
            if (ph < 3) begin
                if (bus.read !== 1'b1 || bus.write !== 1'b0 ||
                    bus.adr_rd !== {src, idx}) bad++;
            end else begin
                if (bus.read !== 1'b0 || bus.write !== 1'b1 ||
                    bus.adr_wr !== idx ||
                    bus.dout !== (idx ^ 8'h5A)) bad++;
                if (bus.write === 1'b1) nwr++;
                if (idx == 8'h10) d10 = bus.dout;
            end
        end
    endtask

    // n cycles with every strobe and flag low
    task automatic quiet(input int n, output int bad);
        bad = 0;
        for (int j = 0; j < n; j++) begin
            step();
            if (bus.active !== 1'b0 || bus.read !== 1'b0 ||
                bus.write !== 1'b0 || bus.drvext !== 1'b0) bad++;
        end
    endtask

    task automatic wr_reg(input logic [7:0] v);
        bus.reg_din   = v;
        bus.reg_write = 1'b1;
        step();
        bus.reg_write = 1'b0;
    endtask

    initial begin
        int bad;
        int nwr;
        logic [7:0] d10;

        bus.reg_din   = 8'h00;
        bus.reg_write = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk("rst_reg_dout", 32'(bus.reg_dout), 32'hFF);
        chk("rst_adr_rd", 32'(bus.adr_rd), 32'h0);
        chk("rst_adr_wr", 32'(bus.adr_wr), 32'h0);
        chk("rst_dout", 32'(bus.dout), 32'hFF);
        chk("rst_strobes",
            32'({bus.read, bus.write, bus.active, bus.drvext}), 32'h0);

        // Page C1: active from edge N+5 for 640 clocks
        wr_reg(8'hC1);
        chk("c1_reg_dout", 32'(bus.reg_dout), 32'hC1);
        quiet(4, bad);
        chk("c1_start_quiet", 32'(bad), 32'd0);
        scan(8'hC1, 1'b1, 640, bad, nwr, d10);
        chk("c1_xfer", 32'(bad), 32'd0);
        chk("c1_writes", 32'(nwr), 32'd160);
        step();
        chk("c1_done_active", 32'(bus.active), 32'h0);
        chk("c1_hold_adr_wr", 32'(bus.adr_wr), 32'h9F);
        chk("c1_hold_adr_rd", 32'(bus.adr_rd), 32'hC19F);

        // VRAM page: no external drive
        wr_reg(8'h80);
        quiet(4, bad);
        chk("p80_start_quiet", 32'(bad), 32'd0);
        scan(8'h80, 1'b0, 640, bad, nwr, d10);
        chk("p80_xfer", 32'(bad), 32'd0);
        chk("p80_dout_at_10", 32'(d10), 32'h4A);
        step();

        // Echo page folds to C3, readback unfolded
        wr_reg(8'hE3);
        chk("e3_reg_dout", 32'(bus.reg_dout), 32'hE3);
        quiet(4, bad);
        scan(8'hC3, 1'b1, 640, bad, nwr, d10);
        chk("e3_xfer", 32'(bad), 32'd0);
        step();

        // Restart at byte 50 phase 1
        wr_reg(8'hC0);
        quiet(4, bad);
        scan(8'hC0, 1'b1, 201, bad, nwr, d10);
        chk("c0_partial", 32'(bad), 32'd0);
        wr_reg(8'hD0);
        chk("restart_edge_read", 32'({bus.read, bus.write}), 32'h2);
        chk("restart_edge_adr", 32'(bus.adr_rd), 32'hC032);
        quiet(4, bad);
        chk("restart_no_write", 32'(bad), 32'd0);
        chk("restart_adr_wr", 32'(bus.adr_wr), 32'h31);
        scan(8'hD0, 1'b1, 640, bad, nwr, d10);
        chk("d0_xfer", 32'(bad), 32'd0);
        step();
        chk("d0_done_active", 32'(bus.active), 32'h0);

        // Reset at byte 80
        wr_reg(8'hC2);
        quiet(4, bad);
        scan(8'hC2, 1'b1, 320, bad, nwr, d10);
        chk("c2_partial", 32'(bad), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_strobes",
            32'({bus.read, bus.write, bus.active, bus.drvext}), 32'h0);
        chk("midrst_reg_dout", 32'(bus.reg_dout), 32'hFF);
        chk("midrst_adr_rd", 32'(bus.adr_rd), 32'h0);
        quiet(20, bad);
        chk("midrst_quiet", 32'(bad), 32'd0);

        // Restart coincident with final write
        wr_reg(8'hC4);
        quiet(4, bad);
        scan(8'hC4, 1'b1, 639, bad, nwr, d10);
        chk("c4_xfer", 32'(bad), 32'd0);
        wr_reg(8'hC5);
        chk("final_write",
            32'({bus.write, bus.active, bus.adr_wr}), 32'h39F);
        chk("final_dout", 32'(bus.dout), 32'hC5);
        quiet(4, bad);
        chk("c5_start_quiet", 32'(bad), 32'd0);
        step();
        chk("c5_first_read",
            32'({bus.active, bus.read, bus.adr_rd}), 32'h3C500);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
